// File: rtl/gpio_int_rst_seq.sv
// -----------------------------------------------------------------------------
// gpio_int_rst_seq
//
// Reset sequencer for the GPIO interrupt subsystem. It runs in the 50 MHz
// domain and drives one reset request per clock domain. After power-up, a
// global soft reset, or a PLL lock loss, every domain is held in reset. The
// sequencer then waits for a filtered PLL lock and releases the domains one
// at a time, lowest index first. Once the sequence is complete it services
// per-domain soft-reset requests.
//
// Ports
//   clk_50m       : sole clock
//   rst_50m       : synchronous reset, active-high
//   i_pll_lock    : PLL lock, already synchronized to clk_50m
//   i_sw_rst_all  : single-cycle pulse that restarts the full sequence
//   i_sw_rst_dom  : single-cycle pulses, one per domain, for individual resets
//   i_clr_flag    : clears o_lock_lost
//   o_rstn_dom    : per-domain reset request, 0 = held in reset
//   o_seq_done    : all domains released and sequencer idle in DONE
//   o_lock_lost   : sticky, lock dropped after the sequence left WAIT_LOCK
//   o_state       : ASSERT=0, WAIT_LOCK=1, RELEASE=2, DONE=3, DOM_RST=4
// -----------------------------------------------------------------------------
module gpio_int_rst_seq #(
   parameter int N_DOM     = 7,
   parameter int HOLD_CYC  = 32,
   parameter int LOCK_FILT = 16,
   parameter int STEP_DLY  = 8,
   parameter int CNT_W     = 8
) (
   input  logic             clk_50m,
   input  logic             rst_50m,
   input  logic             i_pll_lock,
   input  logic             i_sw_rst_all,
   input  logic [N_DOM-1:0] i_sw_rst_dom,
   input  logic             i_clr_flag,
   output logic [N_DOM-1:0] o_rstn_dom,
   output logic             o_seq_done,
   output logic             o_lock_lost,
   output logic [2:0]       o_state
);

   localparam int IDX_W = (N_DOM > 1) ? $clog2(N_DOM) : 1;

   typedef enum logic [2:0] {
      ST_ASSERT    = 3'd0,
      ST_WAIT_LOCK = 3'd1,
      ST_RELEASE   = 3'd2,
      ST_DONE      = 3'd3,
      ST_DOM_RST   = 3'd4
   } state_t;

   state_t             state_q,     state_d;
   logic [CNT_W-1:0]   cnt_q,       cnt_d;
   logic [IDX_W-1:0]   idx_q,       idx_d;
   logic [N_DOM-1:0]   mask_q,      mask_d;       // domains held in DOM_RST
   logic [N_DOM-1:0]   nmask_q,     nmask_d;      // requests queued during DOM_RST
   logic [N_DOM-1:0]   rstn_q,      rstn_d;
   logic               done_q,      done_d;
   logic               lock_lost_q, lock_lost_d;

   logic [CNT_W-1:0]   cnt_inc;
   logic               lock_drop;
   logic               hold_tc;
   logic               filt_tc;
   logic               step_tc;

   // The counter saturates instead of wrapping so a mis-sized parameter can
   // never alias a terminal count.
   assign cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

   assign hold_tc = (cnt_q == CNT_W'(HOLD_CYC - 1));
   assign filt_tc = (cnt_q == CNT_W'(LOCK_FILT - 1));
   assign step_tc = (cnt_q == CNT_W'(STEP_DLY - 1));

   // Lock loss only matters once the filter has accepted the lock; while
   // waiting, lock glitches merely restart the filter.
   assign lock_drop = !i_pll_lock &&
                      ((state_q == ST_RELEASE) || (state_q == ST_DONE) ||
                       (state_q == ST_DOM_RST));

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      idx_d       = idx_q;
      mask_d      = mask_q;
      nmask_d     = nmask_q;
      rstn_d      = rstn_q;
      lock_lost_d = i_clr_flag ? 1'b0 : lock_lost_q;

      if (i_sw_rst_all || lock_drop) begin
         state_d = ST_ASSERT;
         cnt_d   = '0;
         idx_d   = '0;
         mask_d  = '0;
         nmask_d = '0;
         rstn_d  = '0;
         // Setting the flag wins over a same-cycle clear.
         if (lock_drop) begin
            lock_lost_d = 1'b1;
         end
      end else begin
         case (state_q)
            ST_ASSERT: begin
               rstn_d = '0;
               if (hold_tc) begin
                  state_d = ST_WAIT_LOCK;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_inc;
               end
            end

            ST_WAIT_LOCK: begin
               if (!i_pll_lock) begin
                  cnt_d = '0;
               end else if (filt_tc) begin
                  state_d = ST_RELEASE;
                  cnt_d   = '0;
                  idx_d   = '0;
               end else begin
                  cnt_d = cnt_inc;
               end
            end

            ST_RELEASE: begin
               if (step_tc) begin
                  rstn_d = rstn_q | (N_DOM'(1) << idx_q);
                  cnt_d  = '0;
                  if (idx_q == IDX_W'(N_DOM - 1)) begin
                     state_d = ST_DONE;
                  end else begin
                     idx_d = idx_q + IDX_W'(1);
                  end
               end else begin
                  cnt_d = cnt_inc;
               end
            end

            ST_DONE: begin
               mask_d = mask_q | i_sw_rst_dom;
               if (mask_d != '0) begin
                  state_d = ST_DOM_RST;
                  cnt_d   = '0;
                  rstn_d  = ~mask_d;
               end
            end

            ST_DOM_RST: begin
               // Requests for domains already being held are absorbed.
               nmask_d = nmask_q | (i_sw_rst_dom & ~mask_q);
               if (hold_tc) begin
                  rstn_d  = rstn_q | mask_q;
                  mask_d  = nmask_d;
                  nmask_d = '0;
                  state_d = ST_DONE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_inc;
               end
            end

            default: begin
               state_d = ST_ASSERT;
               cnt_d   = '0;
               idx_d   = '0;
               mask_d  = '0;
               nmask_d = '0;
               rstn_d  = '0;
            end
         endcase
      end

      done_d = (state_d == ST_DONE);
   end

   always_ff @(posedge clk_50m) begin
      if (rst_50m) begin
         state_q     <= ST_ASSERT;
         cnt_q       <= '0;
         idx_q       <= '0;
         mask_q      <= '0;
         nmask_q     <= '0;
         rstn_q      <= '0;
         done_q      <= 1'b0;
         lock_lost_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         mask_q      <= mask_d;
         nmask_q     <= nmask_d;
         rstn_q      <= rstn_d;
         done_q      <= done_d;
         lock_lost_q <= lock_lost_d;
      end
   end

   assign o_rstn_dom  = rstn_q;
   assign o_seq_done  = done_q;
   assign o_lock_lost = lock_lost_q;
   assign o_state     = state_q;

endmodule
